// File: rtl/jtag_tdi_driver.sv
// JTAG stimulus driver: walks the target TAP through optional IR and DR scans, shifting
// instruction and boundary-scan pattern LSB first, and flags the window the TDO monitor compares.
module jtag_tdi_driver #(
  parameter int BSC_SIZE  = 14,
  parameter int IR_WIDTH  = 3,
  parameter int RESET_TMS = 5
) (
  input  logic                TCK,
  input  logic                TRST_N,
  input  logic                start,
  input  logic                skip_ir,
  input  logic [IR_WIDTH-1:0] instr,
  input  logic [BSC_SIZE-1:0] pattern,
  output logic                TMS,
  output logic                to_TDI,
  output logic                enable_TDO,
  output logic                strobe,
  output logic                busy,
  output logic                done
);

  localparam int MAX_LEN = (BSC_SIZE > IR_WIDTH) ? BSC_SIZE : IR_WIDTH;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int RST_W   = $clog2(RESET_TMS + 1);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_t;

  typedef enum logic [1:0] {C_RST_SEQ, C_IDLE, C_LAUNCH, C_SCAN} ctrl_t;

  tap_t                tap_q, tap_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [RST_W-1:0]    rst_cnt_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                ir_pend_q;
  logic                scan_seen_q;
  logic [IR_WIDTH-1:0] instr_q;
  logic [BSC_SIZE-1:0] pattern_q;
  logic                tms_d;
  logic                tdi_d;

  function automatic tap_t tap_step(input tap_t s, input logic tms);
    tap_t n;
    n = s;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

  function automatic logic pick_ir(input logic [IR_WIDTH-1:0] v, input logic [CNT_W-1:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < IR_WIDTH; i++)
      if (k == CNT_W'(i)) b = v[i];
    return b;
  endfunction

  function automatic logic pick_dr(input logic [BSC_SIZE-1:0] v, input logic [CNT_W-1:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < BSC_SIZE; i++)
      if (k == CNT_W'(i)) b = v[i];
    return b;
  endfunction

  // Next-state and next-drive logic; TMS/TDI for the coming posedge depend only on
  // the current TAP state, bit counter and latched request.
  always_comb begin
    tap_d  = tap_step(tap_q, TMS);
    ctrl_d = ctrl_q;
    tms_d  = 1'b0;
    tdi_d  = 1'b0;
    case (ctrl_q)
      C_RST_SEQ: begin
        tms_d = (rst_cnt_q < RST_W'(RESET_TMS));
        if (rst_cnt_q == RST_W'(RESET_TMS)) ctrl_d = C_IDLE;
      end
      C_IDLE: begin
        if (start) ctrl_d = C_LAUNCH;
      end
      C_LAUNCH: begin
        ctrl_d = C_SCAN;
      end
      C_SCAN: begin
        case (tap_q)
          RTI, EXIT1_IR, UPD_IR, EXIT1_DR,
          PAUSE_IR, EXIT2_IR, PAUSE_DR, EXIT2_DR: tms_d = 1'b1;
          SEL_DR:   tms_d = ir_pend_q;
          SHIFT_IR: tms_d = (bit_cnt_q == CNT_W'(IR_WIDTH - 1));
          SHIFT_DR: tms_d = (bit_cnt_q == CNT_W'(BSC_SIZE - 1));
          default:  tms_d = 1'b0;
        endcase
        case (tap_q)
          SHIFT_IR: tdi_d = pick_ir(instr_q, bit_cnt_q);
          SHIFT_DR: tdi_d = pick_dr(pattern_q, bit_cnt_q);
          default:  tdi_d = 1'b0;
        endcase
        if (tap_q != RTI && tap_d == RTI) ctrl_d = C_IDLE;
      end
      default: ctrl_d = C_RST_SEQ;
    endcase
  end

  // Posedge: TAP mirror, sequencing control and handshake flags.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tap_q       <= TLR;
      ctrl_q      <= C_RST_SEQ;
      rst_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      ir_pend_q   <= 1'b0;
      scan_seen_q <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else begin
      tap_q  <= tap_d;
      ctrl_q <= ctrl_d;
      done   <= 1'b0;
      if (ctrl_q == C_RST_SEQ && rst_cnt_q != RST_W'(RESET_TMS))
        rst_cnt_q <= rst_cnt_q + RST_W'(1);
      if (tap_d != tap_q)
        bit_cnt_q <= '0;
      else if (tap_q == SHIFT_IR || tap_q == SHIFT_DR)
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      case (ctrl_q)
        C_RST_SEQ: if (ctrl_d == C_IDLE) busy <= 1'b0;
        C_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            ir_pend_q <= ~skip_ir;
          end
        end
        C_SCAN: begin
          if (tap_q == CAP_IR) ir_pend_q <= 1'b0;
          if (ctrl_d == C_IDLE) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            scan_seen_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge TCK) begin
    if (ctrl_q == C_IDLE && start) begin
      instr_q   <= instr;
      pattern_q <= pattern;
    end
  end

  // Negedge: drive the TAP pins half a cycle ahead of the edge that samples them.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TMS        <= 1'b1;
      to_TDI     <= 1'b0;
      enable_TDO <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      TMS        <= tms_d;
      to_TDI     <= tdi_d;
      enable_TDO <= (tap_q == SHIFT_DR);
      if (tap_q == SHIFT_DR && !enable_TDO) strobe <= scan_seen_q;
    end
  end

endmodule
